// File: rtl/preg_alloc_queue_pkg.sv
// Shared sizing, types and constants for the physical-register free queue.
package preg_alloc_queue_pkg;

    localparam int unsigned NUM_PREGS              = 64;
    localparam int unsigned NUM_AREGS              = 32;
    localparam int unsigned MAX_PREDICT_DEPTH      = 4;
    localparam int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH);
    localparam int unsigned PREG_W                 = $clog2(NUM_PREGS);
    localparam int unsigned NUM_INIT_FREE          = NUM_PREGS - NUM_AREGS;

    typedef logic [PREG_W-1:0]                 preg_t;
    // Ring pointer: low bits index the ring, MSB is the wrap bit.
    typedef logic [PREG_W:0]                   ptr_t;
    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_t;

endpackage

// File: rtl/preg_alloc_queue_fl_ckpt_table.sv
// Per-branch snapshot table of the free-queue head pointer: one write port, one async read port.
module fl_ckpt_table
    import preg_alloc_queue_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_en,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] wr_idx,
    input  logic [PREG_W:0]                   wr_data,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] rd_idx,
    output logic [PREG_W:0]                   rd_data
);

    ptr_t slot_q [MAX_PREDICT_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MAX_PREDICT_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = slot_q[rd_idx];

endmodule

// File: rtl/preg_alloc_queue.sv
// Circular free list of physical register IDs: 2-wide allocate, 2-wide release,
// with per-branch head checkpoints for single-cycle rollback.
module preg_alloc_queue
    import preg_alloc_queue_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [1:0]                        alloc_count,
    output logic [PREG_W-1:0]                 preg1,
    output logic [PREG_W-1:0]                 preg2,
    output logic [PREG_W:0]                   num_free,
    input  logic [1:0]                        rel_count,
    input  logic [PREG_W-1:0]                 rel_preg1,
    input  logic [PREG_W-1:0]                 rel_preg2,
    input  logic                              ckpt_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] ckpt_tag,
    input  logic                              branch_shootdown,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag,
    output logic                              overflow_err,
    output logic                              underflow_err
);

    localparam logic [PREG_W+1:0] RING_CAP = (PREG_W + 2)'(NUM_PREGS);

    preg_t ring_q [NUM_PREGS];
    ptr_t  head_q, head_d;
    ptr_t  tail_q, tail_d;
    ptr_t  num_free_q, num_free_d;
    logic  underflow_q, underflow_d;
    logic  overflow_q, overflow_d;

    logic              rel_ok;
    logic [PREG_W+1:0] free_sum;
    logic              ckpt_we;
    ptr_t              ckpt_rd;
    preg_t             head_idx, head_idx1, tail_idx, tail_idx1;

    assign head_idx  = head_q[PREG_W-1:0];
    assign head_idx1 = head_idx + preg_t'(1);
    assign tail_idx  = tail_q[PREG_W-1:0];
    assign tail_idx1 = tail_idx + preg_t'(1);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;

        // Shootdown wins over allocation: the dequeue is discarded along with the wrong path.
        if (branch_shootdown) begin
            head_d = ckpt_rd;
        end else if (ptr_t'(alloc_count) <= num_free_q) begin
            head_d = head_q + ptr_t'(alloc_count);
        end else begin
            underflow_d = 1'b1;
        end

        free_sum = {1'b0, num_free_q} + {{PREG_W{1'b0}}, rel_count};
        rel_ok   = (free_sum <= RING_CAP);
        if (rel_count != 2'd0) begin
            if (rel_ok) begin
                tail_d = tail_q + ptr_t'(rel_count);
            end else begin
                overflow_d = 1'b1;
            end
        end

        num_free_d = tail_d - head_d;
        ckpt_we    = ckpt_valid && !branch_shootdown;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= ptr_t'(NUM_INIT_FREE);
            num_free_q  <= ptr_t'(NUM_INIT_FREE);
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            num_free_q  <= num_free_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Architectural pregs start mapped, so only the upper IDs seed the ring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                ring_q[i] <= (i < NUM_INIT_FREE) ? preg_t'(NUM_AREGS + i) : '0;
            end
        end else if (rel_ok) begin
            if (rel_count != 2'd0) begin
                ring_q[tail_idx] <= rel_preg1;
            end
            if (rel_count[1]) begin
                ring_q[tail_idx1] <= rel_preg2;
            end
        end
    end

    fl_ckpt_table u_ckpt_table (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ckpt_we),
        .wr_idx  (ckpt_tag),
        .wr_data (head_d),
        .rd_idx  (shootdown_branch_tag),
        .rd_data (ckpt_rd)
    );

    assign preg1         = ring_q[head_idx];
    assign preg2         = ring_q[head_idx1];
    assign num_free      = num_free_q;
    assign underflow_err = underflow_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_preg_alloc_queue.sv
// Directed self-checking bench for preg_alloc_queue using immediate assertions.
module tb_preg_alloc_queue;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] alloc_count;
    logic [5:0] preg1, preg2;
    logic [6:0] num_free;
    logic [1:0] rel_count;
    logic [5:0] rel_preg1, rel_preg2;
    logic       ckpt_valid;
    logic [1:0] ckpt_tag;
    logic       branch_shootdown;
    logic [1:0] shootdown_branch_tag;
    logic       overflow_err, underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    preg_alloc_queue dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .alloc_count          (alloc_count),
        .preg1                (preg1),
        .preg2                (preg2),
        .num_free             (num_free),
        .rel_count            (rel_count),
        .rel_preg1            (rel_preg1),
        .rel_preg2            (rel_preg2),
        .ckpt_valid           (ckpt_valid),
        .ckpt_tag             (ckpt_tag),
        .branch_shootdown     (branch_shootdown),
        .shootdown_branch_tag (shootdown_branch_tag),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_count          = 2'd0;
        rel_count            = 2'd0;
        rel_preg1            = '0;
        rel_preg2            = '0;
        ckpt_valid           = 1'b0;
        ckpt_tag             = '0;
        branch_shootdown     = 1'b0;
        shootdown_branch_tag = '0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        do_reset();

        // Reset defaults
        check("rst_num_free", num_free, 32);
        check("rst_preg1", preg1, 32);
        check("rst_preg2", preg2, 33);
        check("rst_overflow", overflow_err, 0);
        check("rst_underflow", underflow_err, 0);

        // Drain all 32 free pregs two at a time
        for (int i = 0; i < 16; i++) begin
            check("drain_preg1", preg1, 32 + 2 * i);
            check("drain_preg2", preg2, 33 + 2 * i);
            alloc_count = 2'd2;
            step();
        end
        alloc_count = 2'd0;
        check("drain_empty", num_free, 0);
        check("drain_no_underflow", underflow_err, 0);

        alloc_count = 2'd1;
        step();
        alloc_count = 2'd0;
        check("underflow_set", underflow_err, 1);
        check("underflow_num_free", num_free, 0);

        // Release into an empty ring, no same-cycle bypass
        rel_count = 2'd2; rel_preg1 = 6'd5; rel_preg2 = 6'd7;
        step();
        check("rel_two_num_free", num_free, 2);
        rel_count = 2'd1; rel_preg1 = 6'd9;
        step();
        rel_count = 2'd0;
        check("rel_three_num_free", num_free, 3);
        check("rel_preg1", preg1, 5);
        check("rel_preg2", preg2, 7);
        alloc_count = 2'd2;
        step();
        alloc_count = 2'd0;
        check("rel_after_alloc", preg1, 9);
        check("rel_after_alloc_free", num_free, 1);
        check("underflow_sticky", underflow_err, 1);

        // Rollback: checkpoint at head=4, allocate 6 more, shoot down
        do_reset();
        check("rst2_underflow", underflow_err, 0);
        alloc_count = 2'd2;
        step();
        step();
        alloc_count = 2'd0;
        check("rb_head4_preg1", preg1, 36);
        ckpt_valid = 1'b1; ckpt_tag = 2'd2;
        step();
        ckpt_valid = 1'b0;
        alloc_count = 2'd2;
        repeat (3) step();
        alloc_count = 2'd0;
        check("rb_head10_preg1", preg1, 42);
        check("rb_head10_free", num_free, 22);
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd2;
        step();
        branch_shootdown = 1'b0;
        check("rb_restore_preg1", preg1, 36);
        check("rb_restore_free", num_free, 28);

        // Checkpoint captures the post-allocation head (4 + 2 = 6)
        ckpt_valid = 1'b1; ckpt_tag = 2'd1; alloc_count = 2'd2;
        step();
        ckpt_valid = 1'b0;
        step();
        alloc_count = 2'd0;
        check("ck_head8_preg1", preg1, 40);

        // Shootdown + alloc + release + checkpoint in one cycle
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd1;
        alloc_count = 2'd2;
        rel_count = 2'd1; rel_preg1 = 6'd3;
        ckpt_valid = 1'b1; ckpt_tag = 2'd3;
        step();
        idle_inputs();
        check("sim_preg1", preg1, 38);
        check("sim_preg2", preg2, 39);
        check("sim_free", num_free, 27);
        check("sim_no_underflow", underflow_err, 0);

        // Walk head to ring[32] where the released preg 3 landed
        alloc_count = 2'd2;
        repeat (13) step();
        alloc_count = 2'd0;
        check("sim_rel_entry", preg1, 3);
        check("sim_rel_free", num_free, 1);

        // Slot 3 must still hold its reset value: the shootdown cycle ignored ckpt_valid
        branch_shootdown = 1'b1; shootdown_branch_tag = 2'd3;
        step();
        branch_shootdown = 1'b0;
        check("ck_ignored_preg1", preg1, 32);
        check("ck_ignored_free", num_free, 33);

        // Overflow: fill the ring completely, then one more release
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rel_count = 2'd2;
            rel_preg1 = 6'(2 * i);
            rel_preg2 = 6'(2 * i + 1);
            step();
        end
        rel_count = 2'd0;
        check("full_free", num_free, 64);
        check("full_no_overflow", overflow_err, 0);
        check("full_preg1", preg1, 32);
        rel_count = 2'd1; rel_preg1 = 6'd40;
        step();
        rel_count = 2'd0;
        check("ovf_set", overflow_err, 1);
        check("ovf_free", num_free, 64);
        check("ovf_no_underflow", underflow_err, 0);

        // Ring wrapped: entries 32..63 now hold 0..31
        alloc_count = 2'd2;
        repeat (16) step();
        alloc_count = 2'd0;
        check("wrap_preg1", preg1, 0);
        check("wrap_preg2", preg2, 1);
        check("wrap_free", num_free, 32);
        check("ovf_sticky", overflow_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
